// File: rtl/icebus_pkg.sv
// Shared definitions for the iCE motor-board status link: frame constants,
// parser/UART state encodings and the decoded status record.
package icebus_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         PAYLOAD_BYTES = 14;
  localparam int         PAYLOAD_BITS  = PAYLOAD_BYTES * 8;

  typedef enum logic [1:0] {
    PARSE_IDLE,
    PARSE_ID,
    PARSE_PAYLOAD,
    PARSE_CHECK
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic [7:0]         motor;
    logic signed [31:0] position;
    logic signed [31:0] velocity;
    logic signed [31:0] displacement;
    logic signed [15:0] current;
  } status_frame_t;

  // Error counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == '1) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first, with a mid-bit sampling scheme.
// byte_valid / framing_error pulse in the cycle of the stop-bit mid-sample.
module uart_rx_byte
  import icebus_pkg::*;
#(
  parameter int BIT_CYCLES = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_error
);

  localparam int CW   = $clog2(BIT_CYCLES);
  localparam int HALF = BIT_CYCLES / 2;

  rx_state_t   state, state_n;
  logic        rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        half_end, bit_end, fall;

  assign half_end = (cnt == CW'(HALF - 1));
  assign bit_end  = (cnt == CW'(BIT_CYCLES - 1));
  assign fall     = rx_prev & ~rx_sync;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_n;
  end

  // Next-state: start on a falling edge, confirm at half bit, 8 data bits, stop.
  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:  if (fall) state_n = RX_START;
      RX_START: if (half_end) state_n = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_idx == 3'd7) state_n = RX_STOP;
      RX_STOP:  if (bit_end) state_n = RX_IDLE;
      default:  state_n = RX_IDLE;
    endcase
  end

  // Bit timer and shift register; timer restarts on every state change and data bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state_n != state || (state == RX_DATA && bit_end)) cnt <= '0;
      else if (state != RX_IDLE)                             cnt <= cnt + CW'(1);
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && bit_end) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign byte_data     = shift;
  assign byte_valid    = (state == RX_STOP) && bit_end && rx_sync;
  assign framing_error = (state == RX_STOP) && bit_end && !rx_sync;

endmodule

// File: rtl/icebus_status_receiver.sv
// Motor status frame receiver: UART bytes -> frame parser -> checksum check,
// with saturating error counters and a one-cycle decoded status strobe.
module icebus_status_receiver
  import icebus_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS     = 6,
  parameter int CLOCK_SPEED_HZ       = 50_000_000,
  parameter int BAUD_RATE            = 1_000_000,
  parameter int FRAME_TIMEOUT_CYCLES = 2000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rx,
  output logic               status_valid,
  output logic [7:0]         status_motor,
  output logic signed [31:0] status_position,
  output logic signed [31:0] status_velocity,
  output logic signed [31:0] status_displacement,
  output logic signed [15:0] status_current,
  output logic [15:0]        checksum_error_count,
  output logic [15:0]        frame_error_count,
  output logic               busy
);

  localparam int BIT_CYCLES = CLOCK_SPEED_HZ / BAUD_RATE;
  localparam int GW         = $clog2(FRAME_TIMEOUT_CYCLES + 1);

  logic [7:0] byte_data;
  logic       byte_valid, framing_error;

  uart_rx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_uart (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .framing_error (framing_error)
  );

  parse_state_t          state, state_n;
  logic [3:0]            byte_idx;
  logic [7:0]            checksum;
  logic [7:0]            frame_motor;
  logic [PAYLOAD_BITS-1:0] frame_payload;
  logic [GW-1:0]         gap_cnt;
  status_frame_t         status_q;

  logic id_ok, bad_id, timeout, abort_frame, check_byte, checksum_ok;

  assign id_ok       = (32'(byte_data) < NUMBER_OF_MOTORS);
  assign bad_id      = (state == PARSE_ID) && byte_valid && !id_ok;
  assign timeout     = (state != PARSE_IDLE) && (gap_cnt == GW'(FRAME_TIMEOUT_CYCLES));
  assign abort_frame = (state != PARSE_IDLE) && (framing_error || timeout || bad_id);
  assign check_byte  = (state == PARSE_CHECK) && byte_valid;
  assign checksum_ok = check_byte && (byte_data == checksum);

  // Parser state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= PARSE_IDLE;
    else        state <= state_n;
  end

  // Parser next-state; any abort condition returns to IDLE first.
  always_comb begin
    state_n = state;
    if (abort_frame) begin
      state_n = PARSE_IDLE;
    end else if (byte_valid) begin
      case (state)
        PARSE_IDLE:    if (byte_data == SYNC_BYTE) state_n = PARSE_ID;
        PARSE_ID:      state_n = PARSE_PAYLOAD;
        PARSE_PAYLOAD: if (byte_idx == 4'(PAYLOAD_BYTES - 1)) state_n = PARSE_CHECK;
        PARSE_CHECK:   state_n = PARSE_IDLE;
        default:       state_n = PARSE_IDLE;
      endcase
    end
  end

  // Frame assembly, running checksum and inter-byte gap timer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_idx      <= '0;
      checksum      <= '0;
      frame_motor   <= '0;
      frame_payload <= '0;
      gap_cnt       <= '0;
    end else begin
      if (state == PARSE_IDLE || byte_valid || framing_error) gap_cnt <= '0;
      else if (!timeout)                                      gap_cnt <= gap_cnt + GW'(1);
      if (byte_valid && state == PARSE_ID) begin
        frame_motor <= byte_data;
        checksum    <= byte_data;
        byte_idx    <= '0;
      end
      if (byte_valid && state == PARSE_PAYLOAD) begin
        frame_payload <= {frame_payload[PAYLOAD_BITS-9:0], byte_data};
        checksum      <= checksum ^ byte_data;
        byte_idx      <= byte_idx + 4'd1;
      end
    end
  end

  // Status latch, strobe and saturating error counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_valid         <= 1'b0;
      status_q             <= '0;
      checksum_error_count <= '0;
      frame_error_count    <= '0;
    end else begin
      status_valid <= 1'b0;
      if (checksum_ok) begin
        status_valid          <= 1'b1;
        status_q.motor        <= frame_motor;
        status_q.position     <= frame_payload[111:80];
        status_q.velocity     <= frame_payload[79:48];
        status_q.displacement <= frame_payload[47:16];
        status_q.current      <= frame_payload[15:0];
      end else if (check_byte) begin
        checksum_error_count <= sat_inc(checksum_error_count);
      end
      if (abort_frame) frame_error_count <= sat_inc(frame_error_count);
    end
  end

  assign status_motor        = status_q.motor;
  assign status_position     = status_q.position;
  assign status_velocity     = status_q.velocity;
  assign status_displacement = status_q.displacement;
  assign status_current      = status_q.current;
  assign busy                = (state != PARSE_IDLE);

endmodule
